wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters.
  - The main pipeline WB stage (destination already chosen by the RegDst mux).
  - The multicycle multiply/divide unit (MDU).
- Buffers MDU results in a small FIFO and tracks pending MDU destinations in a 32-bit scoreboard.
- Drives the issue-stage hazard stall and requests pipeline bubbles when a buffered result starves.

---
 rtl/wb_port_arbiter_pkg.sv | 15 +
 rtl/wb_result_fifo.sv | 62 ++++++
 rtl/wb_port_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // One register-file write request; wdata is DATA_W wide, so DW must not exceed DATA_W.
  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO buffering MDU results; push is also accepted while full if a pop frees a slot.
module wb_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the WB stage and buffered MDU results.
// Optional macro WB_BYPASS_EN: MDU result written straight through when the FIFO is empty and WB is idle.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_we,
  input  logic [4:0]    pipe_wreg,
  input  logic [DW-1:0] pipe_wdata,
  input  logic          mdu_valid,
  input  logic [4:0]    mdu_wreg,
  input  logic [DW-1:0] mdu_wdata,
  output logic          mdu_ready,
  input  logic          issue_valid,
  input  logic [4:0]    issue_wreg,
  input  logic [4:0]    chk_rs,
  input  logic [4:0]    chk_rt,
  input  logic [4:0]    chk_wd,
  output logic          hazard_stall,
  output logic          bubble_req,
  output logic          rf_we,
  output logic [4:0]    rf_wreg,
  output logic [DW-1:0] rf_wdata,
  output logic          waw_err
);

  localparam int FW    = REG_W + DW;
  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  logic [FW-1:0]    head;
  logic [REG_W-1:0] head_wreg;
  logic [DW-1:0]    head_wdata;
  logic             fifo_full, fifo_empty;
  logic             pipe_win, push, pop;
  logic             sb_clr;
  logic [REG_W-1:0] sb_clr_reg;
  wb_req_t          wr_req;

  logic [31:0]      sb_q, sb_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             waw_q, waw_d;

  wb_result_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({mdu_wreg, mdu_wdata}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_wreg, head_wdata} = head;
  assign pipe_win  = pipe_we && (pipe_wreg != REG_ZERO);
  assign mdu_ready = !reset && !fifo_full;

  always_comb begin
    wr_req     = '0;
    pop        = 1'b0;
    sb_clr     = 1'b0;
    sb_clr_reg = REG_ZERO;
    push       = mdu_valid && mdu_ready;
    if (!reset) begin
      if (pipe_win) begin
        wr_req.we    = 1'b1;
        wr_req.wreg  = pipe_wreg;
        wr_req.wdata = DATA_W'(pipe_wdata);
      end else if (!fifo_empty) begin
        // A head bound for r0 is drained without a write.
        pop          = 1'b1;
        sb_clr       = 1'b1;
        sb_clr_reg   = head_wreg;
        wr_req.we    = (head_wreg != REG_ZERO);
        wr_req.wreg  = head_wreg;
        wr_req.wdata = DATA_W'(head_wdata);
      end
`ifdef WB_BYPASS_EN
      else if (!pipe_we && mdu_valid) begin
        push         = 1'b0;
        sb_clr       = 1'b1;
        sb_clr_reg   = mdu_wreg;
        wr_req.we    = (mdu_wreg != REG_ZERO);
        wr_req.wreg  = mdu_wreg;
        wr_req.wdata = DATA_W'(mdu_wdata);
      end
`endif
    end
  end

  assign rf_we    = wr_req.we;
  assign rf_wreg  = wr_req.wreg;
  assign rf_wdata = DW'(wr_req.wdata);

  always_comb begin
    // Clear first so a same-cycle issue of the same register wins.
    sb_d = sb_q;
    if (sb_clr) sb_d[sb_clr_reg] = 1'b0;
    if (issue_valid && (issue_wreg != REG_ZERO)) sb_d[issue_wreg] = 1'b1;
    sb_d[0] = 1'b0;

    age_d = age_q;
    if (pop || fifo_empty)                 age_d = '0;
    else if (age_q < AGE_W'(MAX_WAIT))     age_d = age_q + 1'b1;

    waw_d = waw_q || (pipe_win && sb_q[pipe_wreg]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q  <= '0;
      age_q <= '0;
      waw_q <= 1'b0;
    end else begin
      sb_q  <= sb_d;
      age_q <= age_d;
      waw_q <= waw_d;
    end
  end

  assign hazard_stall = !reset && (sb_q[chk_rs] || sb_q[chk_rt] || sb_q[chk_wd]);
  assign bubble_req   = !reset && (age_q >= AGE_W'(MAX_WAIT));
  assign waw_err      = waw_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=2, MAX_WAIT=4); follows WB_BYPASS_EN if defined.
`timescale 1ns/1ps
module tb_wb_port_arbiter;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_we, mdu_valid, issue_valid;
  logic [4:0]  pipe_wreg, mdu_wreg, issue_wreg, chk_rs, chk_rt, chk_wd;
  logic [31:0] pipe_wdata, mdu_wdata;
  logic        mdu_ready, hazard_stall, bubble_req, rf_we, waw_err;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;

  int tests = 0;
  int fails = 0;

  wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4), .DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_we      (pipe_we),
    .pipe_wreg    (pipe_wreg),
    .pipe_wdata   (pipe_wdata),
    .mdu_valid    (mdu_valid),
    .mdu_wreg     (mdu_wreg),
    .mdu_wdata    (mdu_wdata),
    .mdu_ready    (mdu_ready),
    .issue_valid  (issue_valid),
    .issue_wreg   (issue_wreg),
    .chk_rs       (chk_rs),
    .chk_rt       (chk_rt),
    .chk_wd       (chk_wd),
    .hazard_stall (hazard_stall),
    .bubble_req   (bubble_req),
    .rf_we        (rf_we),
    .rf_wreg      (rf_wreg),
    .rf_wdata     (rf_wdata),
    .waw_err      (waw_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    pipe_we = 0; pipe_wreg = 0; pipe_wdata = 0;
    mdu_valid = 0; mdu_wreg = 0; mdu_wdata = 0;
    issue_valid = 0; issue_wreg = 0;
    chk_rs = 0; chk_rt = 0; chk_wd = 0;
  endtask

  initial begin
    idle();
    #1 reset = 1'b1;
    pipe_we = 1; pipe_wreg = 3; pipe_wdata = 32'hAA; mdu_valid = 1; chk_rs = 5;
    settle();
    check("rst_rf_we",  32'(rf_we), 0);
    check("rst_ready",  32'(mdu_ready), 0);
    check("rst_hazard", 32'(hazard_stall), 0);
    check("rst_bubble", 32'(bubble_req), 0);
    check("rst_waw",    32'(waw_err), 0);
    cyc(); cyc();
    idle(); reset = 1'b0; settle();
    check("rel_ready", 32'(mdu_ready), 1);

    // Priority: pipe write beats a queued MDU result
    cyc();
    pipe_we = 1; pipe_wreg = 3; pipe_wdata = 32'hAA;
    mdu_valid = 1; mdu_wreg = 7; mdu_wdata = 32'h55;
    settle();
    check("pri_we",    32'(rf_we), 1);
    check("pri_wreg",  32'(rf_wreg), 3);
    check("pri_wdata", rf_wdata, 32'hAA);
    cyc(); mdu_valid = 0; settle();
    check("pri_hold_wreg", 32'(rf_wreg), 3);
    cyc(); pipe_we = 0; settle();
    check("pri_head_we",    32'(rf_we), 1);
    check("pri_head_wreg",  32'(rf_wreg), 7);
    check("pri_head_wdata", rf_wdata, 32'h55);
    cyc(); settle();
    check("pri_empty_we", 32'(rf_we), 0);

    // Scoreboard on register 8, including set-wins on same-cycle issue and clear
    issue_valid = 1; issue_wreg = 8; chk_rt = 8; settle();
    check("sb_pre", 32'(hazard_stall), 0);
    cyc(); issue_valid = 0; settle();
    check("sb_set", 32'(hazard_stall), 1);
    pipe_we = 1; pipe_wreg = 2; pipe_wdata = 32'h22;
    mdu_valid = 1; mdu_wreg = 8; mdu_wdata = 32'h88; settle();
    check("sb_wait", 32'(hazard_stall), 1);
    cyc(); pipe_we = 0; mdu_valid = 0; issue_valid = 1; issue_wreg = 8; settle();
    check("sb_pop_wreg", 32'(rf_wreg), 8);
    check("sb_pop_data", rf_wdata, 32'h88);
    cyc(); issue_valid = 0; settle();
    check("sb_set_wins", 32'(hazard_stall), 1);
    pipe_we = 1; mdu_valid = 1; mdu_wdata = 32'h89; settle();
    cyc(); pipe_we = 0; mdu_valid = 0; settle();
    check("sb_pop2_wreg", 32'(rf_wreg), 8);
    check("sb_pop2_stall", 32'(hazard_stall), 1);
    cyc(); settle();
    check("sb_cleared", 32'(hazard_stall), 0);
    chk_rt = 0;

    // Starvation: one queued entry while WB writes every cycle
    pipe_we = 1; pipe_wreg = 2; mdu_valid = 1; mdu_wreg = 10; mdu_wdata = 32'h10A; settle();
    check("stv_c0", 32'(bubble_req), 0);
    cyc(); mdu_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      settle();
      check($sformatf("stv_c%0d", k), 32'(bubble_req), 32'(k >= 5));
      cyc();
    end
    pipe_we = 0; settle();
    check("stv_pop_we",   32'(rf_we), 1);
    check("stv_pop_wreg", 32'(rf_wreg), 10);
    check("stv_hold",     32'(bubble_req), 1);
    cyc(); settle();
    check("stv_drop",    32'(bubble_req), 0);
    check("stv_idle_we", 32'(rf_we), 0);

    // Full FIFO, r0 result, WAW detection
    issue_valid = 1; issue_wreg = 12; settle();
    cyc(); issue_valid = 0; settle();
    check("waw_clean", 32'(waw_err), 0);
    pipe_we = 1; pipe_wreg = 2; mdu_valid = 1; mdu_wreg = 0; mdu_wdata = 32'hDEAD; settle();
    check("full_r0", 32'(mdu_ready), 1);
    cyc(); mdu_wreg = 12; mdu_wdata = 32'hC; settle();
    check("full_r1", 32'(mdu_ready), 1);
    cyc(); mdu_wreg = 13; mdu_wdata = 32'hD; settle();
    check("full_r2", 32'(mdu_ready), 0);
    cyc(); mdu_valid = 0; pipe_wreg = 12; settle();
    check("waw_pre", 32'(waw_err), 0);
    cyc(); pipe_we = 0; settle();
    check("r0_pop_we",  32'(rf_we), 0);
    check("waw_set",    32'(waw_err), 1);
    check("full_still", 32'(mdu_ready), 0);
    cyc(); mdu_valid = 1; mdu_wreg = 13; mdu_wdata = 32'hE; settle();
    check("full_h12_wreg",  32'(rf_wreg), 12);
    check("full_h12_data",  rf_wdata, 32'hC);
    check("full_h12_ready", 32'(mdu_ready), 1);
    cyc(); mdu_valid = 0; settle();
    check("full_h13_wreg", 32'(rf_wreg), 13);
    check("full_h13_data", rf_wdata, 32'hE);
    cyc(); chk_rs = 12; settle();
    check("full_done_we", 32'(rf_we), 0);
    check("waw_sticky",   32'(waw_err), 1);
    check("sb12_clear",   32'(hazard_stall), 0);
    chk_rs = 0;

    // Bypass (or one-cycle FIFO latency when bypass is compiled out)
    issue_valid = 1; issue_wreg = 4; settle();
    cyc(); issue_valid = 0; chk_rs = 4;
    mdu_valid = 1; mdu_wreg = 4; mdu_wdata = 32'h1; settle();
    check("byp_stall", 32'(hazard_stall), 1);
    check("byp_we0",   32'(rf_we), 32'(BYP));
    check("byp_wreg0", 32'(rf_wreg), BYP ? 32'd4 : 32'd0);
    cyc(); mdu_valid = 0; settle();
    check("byp_we1",    32'(rf_we), 32'(!BYP));
    check("byp_wreg1",  32'(rf_wreg), BYP ? 32'd0 : 32'd4);
    check("byp_wdata1", rf_wdata, BYP ? 32'd0 : 32'd1);
    check("byp_stall1", 32'(hazard_stall), 32'(!BYP));
    cyc(); settle();
    check("byp_stall2", 32'(hazard_stall), 0);
    chk_rs = 0;

    // Reset mid-operation with two queued entries and bits 5, 9 pending
    issue_valid = 1; issue_wreg = 5; cyc();
    issue_wreg = 9; cyc();
    issue_valid = 0;
    pipe_we = 1; pipe_wreg = 2; mdu_valid = 1; mdu_wreg = 5; mdu_wdata = 32'h5; cyc();
    mdu_wreg = 9; mdu_wdata = 32'h9; cyc();
    mdu_valid = 0; chk_rs = 5; settle();
    check("rm_pre_stall", 32'(hazard_stall), 1);
    check("rm_pre_ready", 32'(mdu_ready), 0);
    #2 reset = 1'b1; settle();
    check("rm_we",    32'(rf_we), 0);
    check("rm_ready", 32'(mdu_ready), 0);
    #1 reset = 1'b0; settle();
    check("rm_rel_stall", 32'(hazard_stall), 0);
    check("rm_rel_ready", 32'(mdu_ready), 1);
    check("rm_rel_waw",   32'(waw_err), 0);
    cyc(); pipe_we = 0; settle();
    check("rm_empty_we", 32'(rf_we), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
